// File: rtl/perspective_projector.sv
// Sequential perspective projector: maps path distance onto the vanishing-point line
// with one shared restoring divider. Optional round-half-up quotients via PROJECTOR_ROUND_EN.
module perspective_projector #(
  parameter int unsigned S         = 20,
  parameter int unsigned SIZE_NEAR = 24,
  parameter int unsigned CW        = 11,
  parameter int unsigned DW        = 12,
  parameter int unsigned SW        = 8,
  parameter int unsigned NW        = 16,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    distance,
  input  logic [CW-1:0]    x0,
  input  logic [CW-1:0]    y0,
  input  logic [CW-1:0]    x1,
  input  logic [CW-1:0]    y1,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    x,
  output logic [CW-1:0]    y,
  output logic [SW-1:0]    size,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned DDW   = DW + 1;
  localparam int unsigned CNT_W = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, DIV_Y, DIV_X, DIV_S, DONE} state_t;

  state_t state, state_next;

  logic [DDW-1:0]   d_reg;
  logic [CW-1:0]    dy_reg, dx_reg, x0_reg, y0_reg;
  logic             sy_reg, sx_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [NW-1:0]    num_reg;
  logic [DDW-1:0]   rem_reg;
  logic [CNT_W-1:0] cnt;
  logic [CW-1:0]    ny_reg, nx_reg;

  logic             accept, last;
  logic [DDW:0]     trial, diff;
  logic             qbit;
  logic [DDW-1:0]   rem_next;
  logic [NW-1:0]    quo_next;
  logic [NW-1:0]    rnd, num_y, num_x, num_s;
  logic [NW-1:0]    ny_lim, nx_lim, q_lim;
  logic [SW-1:0]    size_sat;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && (state == IDLE);
  assign last     = (cnt == CNT_W'(NW - 1));

  // One restoring step: shift in the next numerator bit, subtract if it fits
  assign trial    = {rem_reg, num_reg[NW-1]};
  assign diff     = trial - {1'b0, d_reg};
  assign qbit     = ~diff[DDW];
  assign rem_next = qbit ? diff[DDW-1:0] : trial[DDW-1:0];
  assign quo_next = {num_reg[NW-2:0], qbit};

`ifdef PROJECTOR_ROUND_EN
  assign rnd    = NW'(d_reg >> 1);
  assign ny_lim = (quo_next > NW'(dy_reg)) ? NW'(dy_reg) : quo_next;
  assign nx_lim = (quo_next > NW'(dx_reg)) ? NW'(dx_reg) : quo_next;
`else
  assign rnd    = '0;
  assign ny_lim = quo_next;
  assign nx_lim = quo_next;
`endif
  assign q_lim    = quo_next;
  assign size_sat = (q_lim > NW'(2 ** SW - 1)) ? {SW{1'b1}} : SW'(q_lim);

  assign num_y = NW'(S) * NW'(dy_reg) + rnd;
  assign num_x = NW'(S) * NW'(dx_reg) + rnd;
  assign num_s = NW'(S * SIZE_NEAR) + rnd;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = LOAD;
      LOAD:    state_next = DIV_Y;
      DIV_Y:   if (last) state_next = DIV_X;
      DIV_X:   if (last) state_next = DIV_S;
      DIV_S:   if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, divider datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_reg     <= '0;
      dy_reg    <= '0;
      dx_reg    <= '0;
      x0_reg    <= '0;
      y0_reg    <= '0;
      sy_reg    <= 1'b0;
      sx_reg    <= 1'b0;
      tag_reg   <= '0;
      num_reg   <= '0;
      rem_reg   <= '0;
      cnt       <= '0;
      ny_reg    <= '0;
      nx_reg    <= '0;
      out_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      size      <= '0;
      tag_out   <= '0;
    end else begin
      if (accept) begin
        d_reg   <= DDW'(distance) + DDW'(S);
        dy_reg  <= (y1 >= y0) ? (y1 - y0) : (y0 - y1);
        dx_reg  <= (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        sy_reg  <= (y1 < y0);
        sx_reg  <= (x1 < x0);
        x0_reg  <= x0;
        y0_reg  <= y0;
        tag_reg <= tag_in;
      end
      case (state)
        LOAD: begin
          num_reg <= num_y;
          rem_reg <= '0;
          cnt     <= '0;
        end
        DIV_Y, DIV_X, DIV_S: begin
          num_reg <= quo_next;
          rem_reg <= rem_next;
          cnt     <= cnt + CNT_W'(1);
          if (last) begin
            rem_reg <= '0;
            cnt     <= '0;
            if (state == DIV_Y) begin
              ny_reg  <= CW'(ny_lim);
              num_reg <= num_x;
            end else if (state == DIV_X) begin
              nx_reg  <= CW'(nx_lim);
              num_reg <= num_s;
            end else begin
              y         <= sy_reg ? (y0_reg - ny_reg) : (y0_reg + ny_reg);
              x         <= sx_reg ? (x0_reg - nx_reg) : (x0_reg + nx_reg);
              size      <= size_sat;
              tag_out   <= tag_reg;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perspective_projector.sv
// Directed self-checking bench for perspective_projector (default parameters).
`timescale 1ns/1ps
module tb_perspective_projector;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] distance;
  logic [10:0] x0, y0, x1, y1;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] x, y;
  logic [7:0]  size;
  logic [3:0]  tag_out;

  int tests = 0;
  int fails = 0;

  perspective_projector dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .distance(distance), .x0(x0), .y0(y0), .x1(x1), .y1(y1), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .y(y), .size(size),
    .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic [11:0] d, input logic [10:0] ax0, input logic [10:0] ay0,
                         input logic [10:0] ax1, input logic [10:0] ay1, input logic [3:0] t);
    distance = d; x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; tag_in = t;
  endtask

  // Issue a request, return cycles from accept edge to out_valid (200 on timeout)
  task automatic run_req(input logic [11:0] d, input logic [10:0] ax0, input logic [10:0] ay0,
                         input logic [10:0] ax1, input logic [10:0] ay1, input logic [3:0] t,
                         output int lat);
    int guard;
    set_req(d, ax0, ay0, ax1, ay1, t);
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin step(); guard++; end
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin step(); lat++; end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_req(12'd0, 11'd0, 11'd0, 11'd0, 11'd0, 4'd0);
    step(); step();
    reset = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || x !== 11'd0 || y !== 11'd0 ||
        size !== 8'd0 || tag_out !== 4'd0) begin
      fails++;
      $display("FAIL reset: ov=%b ir=%b x=%0d y=%0d size=%0d tag=%0d, required ov=0 ir=1 all 0",
               out_valid, in_ready, x, y, size, tag_out);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_out_ready: ov=%b ir=%b, required ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_near();
    int lat;
    run_req(12'd0, 11'd320, 11'd100, 11'd400, 11'd460, 4'd3, lat);
    tests++;
    if (lat !== 49) begin
      fails++;
      $display("FAIL near_latency: got %0d, required 49", lat);
    end
    tests++;
    if (x !== 11'd400 || y !== 11'd460 || size !== 8'd24 || tag_out !== 4'd3) begin
      fails++;
      $display("FAIL near_result: x=%0d y=%0d size=%0d tag=%0d, required 400 460 24 3",
               x, y, size, tag_out);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL near_busy: in_ready=%b, required 0", in_ready);
    end
    pop();
  endtask

  task automatic test_mid();
    int lat;
    run_req(12'd20, 11'd320, 11'd100, 11'd400, 11'd460, 4'd7, lat);
    tests++;
    if (lat !== 49 || x !== 11'd360 || y !== 11'd280 || size !== 8'd12 || tag_out !== 4'd7) begin
      fails++;
      $display("FAIL mid: lat=%0d x=%0d y=%0d size=%0d tag=%0d, required 49 360 280 12 7",
               lat, x, y, size, tag_out);
    end
    pop();
  endtask

  task automatic test_zero_dx();
    int lat;
    run_req(12'd5, 11'd100, 11'd50, 11'd100, 11'd90, 4'd9, lat);
    tests++;
    if (lat !== 49 || x !== 11'd100 || y !== 11'd82 || size !== 8'd19 || tag_out !== 4'd9) begin
      fails++;
      $display("FAIL zero_dx: lat=%0d x=%0d y=%0d size=%0d tag=%0d, required 49 100 82 19 9",
               lat, x, y, size, tag_out);
    end
    pop();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_req(12'd60, 11'd320, 11'd400, 11'd200, 11'd40, 4'd2, lat);
    tests++;
    if (lat !== 49 || x !== 11'd290 || y !== 11'd310 || size !== 8'd6 || tag_out !== 4'd2) begin
      fails++;
      $display("FAIL negdir: lat=%0d x=%0d y=%0d size=%0d tag=%0d, required 49 290 310 6 2",
               lat, x, y, size, tag_out);
    end
    set_req(12'd20, 11'd320, 11'd100, 11'd400, 11'd460, 4'd5);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || x !== 11'd290 || y !== 11'd310 ||
          size !== 8'd6 || tag_out !== 4'd2) begin
        fails++;
        $display("FAIL hold[%0d]: ov=%b ir=%b x=%0d y=%0d size=%0d tag=%0d, required 1 0 290 310 6 2",
                 i, out_valid, in_ready, x, y, size, tag_out);
      end
    end
    pop();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || x !== 11'd290 || tag_out !== 4'd2) begin
      fails++;
      $display("FAIL after_pop: ov=%b ir=%b x=%0d tag=%0d, required 0 1 290 2",
               out_valid, in_ready, x, tag_out);
    end
    step();
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL pending_accept: in_ready=%b, required 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 200) begin step(); lat++; end
    tests++;
    if (lat !== 49 || x !== 11'd360 || y !== 11'd280 || size !== 8'd12 || tag_out !== 4'd5) begin
      fails++;
      $display("FAIL pending_result: lat=%0d x=%0d y=%0d size=%0d tag=%0d, required 49 360 280 12 5",
               lat, x, y, size, tag_out);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    int lat;
    set_req(12'd0, 11'd320, 11'd100, 11'd400, 11'd460, 4'd1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    reset = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || x !== 11'd0 || size !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid: ov=%b ir=%b x=%0d size=%0d, required 0 1 0 0",
               out_valid, in_ready, x, size);
    end
    step(); step();
    reset = 1'b0;
    step();
    run_req(12'd20, 11'd320, 11'd100, 11'd400, 11'd460, 4'd6, lat);
    tests++;
    if (lat !== 49 || x !== 11'd360 || y !== 11'd280 || size !== 8'd12 || tag_out !== 4'd6) begin
      fails++;
      $display("FAIL post_reset: lat=%0d x=%0d y=%0d size=%0d tag=%0d, required 49 360 280 12 6",
               lat, x, y, size, tag_out);
    end
    pop();
  endtask

  task automatic test_far();
    int lat;
    logic [10:0] exp_y;
`ifdef PROJECTOR_ROUND_EN
    exp_y = 11'd102;
`else
    exp_y = 11'd101;
`endif
    run_req(12'd4095, 11'd320, 11'd100, 11'd400, 11'd460, 4'd15, lat);
    tests++;
    if (lat !== 49 || x !== 11'd320 || y !== exp_y || size !== 8'd0 || tag_out !== 4'd15) begin
      fails++;
      $display("FAIL far: lat=%0d x=%0d y=%0d size=%0d tag=%0d, required 49 320 %0d 0 15",
               lat, x, y, size, tag_out, exp_y);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_near();
    test_mid();
    test_zero_dx();
    test_back_to_back();
    test_reset_mid();
    test_far();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
